// File: rtl/uart_io_pkg.sv
// Shared definitions for the uart_io_port J1 I/O responder: register offsets,
// status bit positions and the RX/TX pacing FSM state encodings.
package uart_io_pkg;

  localparam logic [15:0] RX_OFS   = 16'd0;
  localparam logic [15:0] TX_OFS   = 16'd1;
  localparam logic [15:0] STAT_OFS = 16'd2;

  localparam int unsigned ST_RX_AVAIL = 0;
  localparam int unsigned ST_TX_READY = 1;
  localparam int unsigned ST_RX_OVF   = 2;
  localparam int unsigned ST_TX_DROP  = 3;
  localparam int unsigned ST_IEN      = 8;

  typedef enum logic {
    RX_IDLE,
    RX_HOLD
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter; push when full and pop when empty
// are ignored, simultaneous push/pop keeps the count unchanged.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_io_port.sv
// J1 I/O-bus front end for buart: buffered RX/TX FIFOs, status register and
// rd/wr strobe pacing. Optional interrupt output under macro UART_IRQ_EN.
module uart_io_port #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        uart_rd,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_valid,
  input  logic        uart_busy
`ifdef UART_IRQ_EN
  ,
  output logic        irq
`endif
);

  import uart_io_pkg::*;

  localparam logic [15:0] ADDR_RX   = BASE_ADDR + RX_OFS;
  localparam logic [15:0] ADDR_TX   = BASE_ADDR + TX_OFS;
  localparam logic [15:0] ADDR_STAT = BASE_ADDR + STAT_OFS;

  rx_state_t   r_rx_state;
  tx_state_t   r_tx_state;
  logic [15:0] r_io_din;
  logic        r_uart_wr;
  logic [7:0]  r_tx_data;
  logic        r_rx_ovf;
  logic        r_tx_drop;

  logic        w_rd_rx;
  logic        w_rd_stat;
  logic        w_wr_tx;
  logic        w_wr_stat;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_rx_rdata;
  logic        w_rx_ovf_set;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic [7:0]  w_tx_rdata;
  logic        w_ien;
  logic [15:0] w_status;
  logic        w_unused_dout;

  assign w_rd_rx   = io_rd && (io_addr == ADDR_RX);
  assign w_rd_stat = io_rd && (io_addr == ADDR_STAT);
  assign w_wr_tx   = io_wr && (io_addr == ADDR_TX);
  assign w_wr_stat = io_wr && (io_addr == ADDR_STAT);

  // The ack is decoded straight from RX_IDLE so the byte is captured in the
  // same cycle buart sees uart_rd; RX_HOLD then covers buart dropping valid.
  assign w_rx_push    = !reset && (r_rx_state == RX_IDLE) && uart_valid && !w_rx_full;
  assign w_rx_pop     = w_rd_rx && !w_rx_empty;
  assign w_rx_ovf_set = (r_rx_state == RX_IDLE) && uart_valid && w_rx_full;
  assign w_tx_push    = w_wr_tx;
  assign w_tx_pop     = !reset && (r_tx_state == TX_IDLE) && !w_tx_empty && !uart_busy;

  assign io_din       = r_io_din;
  assign uart_rd      = w_rx_push;
  assign uart_wr      = r_uart_wr;
  assign uart_tx_data = r_tx_data;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_rx_push),
    .i_wdata (uart_rx_data),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_rdata),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_tx_push),
    .i_wdata (io_dout[7:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_RX_AVAIL] = !w_rx_empty;
    w_status[ST_TX_READY] = !w_tx_full;
    w_status[ST_RX_OVF]   = r_rx_ovf;
    w_status[ST_TX_DROP]  = r_tx_drop;
    w_status[ST_IEN]      = w_ien;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_io_din  <= '0;
      r_rx_ovf  <= 1'b0;
      r_tx_drop <= 1'b0;
    end else begin
      if (w_rd_rx) begin
        r_io_din <= w_rx_empty ? '0 : {8'h00, w_rx_rdata};
      end else if (w_rd_stat) begin
        r_io_din <= w_status;
      end
      // A new event in the same cycle as a clear leaves the flag set.
      if (w_rx_ovf_set) begin
        r_rx_ovf <= 1'b1;
      end else if (w_wr_stat && io_dout[ST_RX_OVF]) begin
        r_rx_ovf <= 1'b0;
      end
      if (w_wr_tx && w_tx_full) begin
        r_tx_drop <= 1'b1;
      end else if (w_wr_stat && io_dout[ST_TX_DROP]) begin
        r_tx_drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
    end else begin
      case (r_rx_state)
        RX_IDLE: if (w_rx_push) r_rx_state <= RX_HOLD;
        RX_HOLD: r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
      r_uart_wr  <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_uart_wr <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_pop) begin
            r_uart_wr  <= 1'b1;
            r_tx_data  <= w_tx_rdata;
            r_tx_state <= TX_START;
          end
        end
        TX_START: r_tx_state <= TX_WAIT;
        TX_WAIT:  if (!uart_busy) r_tx_state <= TX_IDLE;
        default:  r_tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef UART_IRQ_EN
  logic r_ien;
  logic r_irq;

  assign w_ien = r_ien;
  assign irq   = r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ien <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr_stat) begin
        r_ien <= io_dout[ST_IEN];
      end
      r_irq <= r_ien && !w_rx_empty;
    end
  end

  assign w_unused_dout = &{1'b0, io_dout[15:9]};
`else
  assign w_ien         = 1'b0;
  assign w_unused_dout = &{1'b0, io_dout[15:8]};
`endif

endmodule

// File: tb/tb_uart_io_port.sv
// Self-checking bench for uart_io_port with a behavioural buart model.
// Build with +define+UART_IRQ_EN to also exercise the interrupt output.
module tb_uart_io_port;

  localparam logic [15:0] BASE     = 16'h4000;
  localparam int          RX_DEPTH = 8;
  localparam int          TX_DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;
  logic        uart_rd;
  logic        uart_wr;
  logic [7:0]  uart_tx_data;
  logic [7:0]  uart_rx_data;
  logic        uart_valid;
  logic        uart_busy;
`ifdef UART_IRQ_EN
  logic        irq;
`endif

  uart_io_port #(
    .BASE_ADDR (BASE),
    .RX_DEPTH  (RX_DEPTH),
    .TX_DEPTH  (TX_DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .io_addr      (io_addr),
    .io_dout      (io_dout),
    .io_din       (io_din),
    .uart_rd      (uart_rd),
    .uart_wr      (uart_wr),
    .uart_tx_data (uart_tx_data),
    .uart_rx_data (uart_rx_data),
    .uart_valid   (uart_valid),
    .uart_busy    (uart_busy)
`ifdef UART_IRQ_EN
    ,
    .irq          (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // buart model state
  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  int         rd_cnt = 0;
  int         wr_cnt = 0;
  int         busy_len = 20;
  int         busy_cnt;
  logic       busy_force = 1'b0;
  logic       rd_seen = 1'b0;
  logic       wr_seen = 1'b0;

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, got, exp);
    end
  endtask

  // Observe strobes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    rd_seen = uart_rd;
    wr_seen = uart_wr;
    if (uart_rd) rd_cnt++;
    if (uart_wr) begin
      wr_cnt++;
      tx_got.push_back(uart_tx_data);
      check("wr_only_when_idle", 16'(uart_busy), 16'd0);
    end
  end

  // buart responder: pops its held byte on an ack, goes busy after uart_wr.
  initial begin
    uart_valid   = 1'b0;
    uart_rx_data = 8'h00;
    uart_busy    = 1'b0;
    busy_cnt     = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_seen && rx_q.size() > 0) void'(rx_q.pop_front());
      if (wr_seen) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      uart_busy    = busy_force || (busy_cnt != 0);
      uart_valid   = (rx_q.size() != 0);
      uart_rx_data = uart_valid ? rx_q[0] : 8'h00;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    io_rd   = 1'b1;
    @(posedge clk);
    #2;
    io_rd = 1'b0;
    d     = io_din;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] v);
    io_addr = a;
    io_dout = v;
    io_wr   = 1'b1;
    @(posedge clk);
    #2;
    io_wr = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  ofs;
    logic [15:0] wdata;
    logic [15:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl[NV];

  logic [15:0] d;
  int          base_rd;
  int          base_wr;
  logic [7:0]  rx_model[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  b;

  initial begin
    tbl[0]  = '{1'b0, 2'd2, 16'h0000, 16'h0003, "stat_rx_avail"};
    tbl[1]  = '{1'b0, 2'd0, 16'h0000, 16'h0041, "rx_data_41"};
    tbl[2]  = '{1'b0, 2'd2, 16'h0000, 16'h0002, "stat_after_pop"};
    tbl[3]  = '{1'b0, 2'd0, 16'h0000, 16'h0000, "rx_read_empty"};
    tbl[4]  = '{1'b0, 2'd2, 16'h0000, 16'h0002, "stat_still_empty"};
    tbl[5]  = '{1'b0, 2'd3, 16'h0000, 16'h0002, "unmapped_read_holds"};
    tbl[6]  = '{1'b1, 2'd2, 16'h000C, 16'h0000, "clear_noop"};
    tbl[7]  = '{1'b0, 2'd2, 16'h0000, 16'h0002, "stat_after_clear"};
    tbl[8]  = '{1'b1, 2'd2, 16'h0100, 16'h0000, "ien_write"};
`ifdef UART_IRQ_EN
    tbl[9]  = '{1'b0, 2'd2, 16'h0000, 16'h0102, "stat_ien"};
`else
    tbl[9]  = '{1'b0, 2'd2, 16'h0000, 16'h0002, "stat_ien"};
`endif
    tbl[10] = '{1'b1, 2'd2, 16'h0000, 16'h0000, "ien_clear"};

    io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_io_din", io_din, 16'h0000);
    check("rst_uart_rd", 16'(uart_rd), 16'd0);
    check("rst_uart_wr", 16'(uart_wr), 16'd0);
    check("rst_tx_data", 16'(uart_tx_data), 16'h0000);
    cpu_read(BASE + 16'd2, d);
    check("rst_status", d, 16'h0002);

    // Single RX byte, then register table.
    base_rd = rd_cnt;
    rx_q.push_back(8'h41);
    tick(10);
    check("single_rx_pulses", 16'(rd_cnt - base_rd), 16'd1);
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) begin
        cpu_write(BASE + 16'(tbl[i].ofs), tbl[i].wdata);
      end else begin
        cpu_read(BASE + 16'(tbl[i].ofs), d);
        check(tbl[i].name, d, tbl[i].exp);
      end
    end

    // RX overflow: nine bytes with the CPU idle.
    base_rd = rd_cnt;
    for (int i = 0; i < 9; i++) rx_q.push_back(8'(i));
    tick(40);
    check("ovf_pulses", 16'(rd_cnt - base_rd), 16'd8);
    check("ovf_byte_held", 16'(uart_valid), 16'd1);
    cpu_read(BASE + 16'd2, d);
    check("ovf_status", d, 16'h0007);
    for (int i = 0; i < 8; i++) begin
      cpu_read(BASE, d);
      check("ovf_drain", d, 16'(i));
    end
    tick(2);
    cpu_read(BASE, d);
    check("ovf_ninth", d, 16'h0008);
    check("ovf_total_pulses", 16'(rd_cnt - base_rd), 16'd9);
    cpu_write(BASE + 16'd2, 16'h0004);
    cpu_read(BASE + 16'd2, d);
    check("ovf_cleared", d, 16'h0002);

    // Simultaneous UART push and CPU pop with three entries queued.
    rx_q.push_back(8'hA0); rx_q.push_back(8'hA1); rx_q.push_back(8'hA2);
    tick(12);
    rx_q.push_back(8'hA3);
    tick(1);
    io_addr = BASE;
    io_rd   = 1'b1;
    @(negedge clk);
    check("simul_uart_rd", 16'(uart_rd), 16'd1);
    @(posedge clk);
    #2;
    io_rd = 1'b0;
    check("simul_pop_a0", io_din, 16'h00A0);
    for (int i = 1; i < 4; i++) begin
      cpu_read(BASE, d);
      check("simul_order", d, 16'h00A0 + 16'(i));
    end
    cpu_read(BASE, d);
    check("simul_then_empty", d, 16'h0000);

    // TX burst with the transmitter held busy until the FIFO fills.
    tx_got.delete();
    base_wr    = wr_cnt;
    busy_len   = 20;
    busy_force = 1'b1;
    tick(1);
    for (int i = 0; i < 9; i++) cpu_write(BASE + 16'd1, 16'h0010 + 16'(i));
    cpu_read(BASE + 16'd2, d);
    check("tx_full_drop_status", d, 16'h0008);
    busy_force = 1'b0;
    for (int i = 0; i < 400 && (wr_cnt - base_wr) < 8; i++) tick(1);
    tick(60);
    check("tx_burst_pulses", 16'(wr_cnt - base_wr), 16'd8);
    for (int i = 0; i < 8 && i < tx_got.size(); i++)
      check("tx_burst_byte", 16'(tx_got[i]), 16'h0010 + 16'(i));
    cpu_write(BASE + 16'd2, 16'h0008);
    cpu_read(BASE + 16'd2, d);
    check("tx_drop_cleared", d, 16'h0002);

    // Reset while a byte is in flight and another waits in the TX FIFO.
    rx_q.push_back(8'h33);
    base_wr = wr_cnt;
    cpu_write(BASE + 16'd1, 16'h0021);
    cpu_write(BASE + 16'd1, 16'h0022);
    for (int i = 0; i < 20 && wr_cnt == base_wr; i++) tick(1);
    check("pre_reset_wr", 16'(wr_cnt - base_wr), 16'd1);
    tick(3);
    do_reset(2);
    check("mid_rst_io_din", io_din, 16'h0000);
    check("mid_rst_tx_data", 16'(uart_tx_data), 16'h0000);
    tick(60);
    check("mid_rst_no_wr", 16'(wr_cnt - base_wr), 16'd1);
    cpu_read(BASE + 16'd2, d);
    check("mid_rst_status", d, 16'h0002);

`ifdef UART_IRQ_EN
    cpu_write(BASE + 16'd2, 16'h0100);
    rx_q.push_back(8'h55);
    for (int i = 0; i < 10 && !uart_rd; i++) @(negedge clk);
    check("irq_before_avail", 16'(irq), 16'd0);
    @(posedge clk); #2;
    check("irq_lat_avail", 16'(irq), 16'd0);
    @(posedge clk); #2;
    check("irq_rise", 16'(irq), 16'd1);
    cpu_read(BASE, d);
    check("irq_byte", d, 16'h0055);
    check("irq_hold_one", 16'(irq), 16'd1);
    tick(1);
    check("irq_fall", 16'(irq), 16'd0);
    cpu_write(BASE + 16'd2, 16'h0000);
`endif

    // Randomised traffic against queue-based scoreboards.
    rx_model.delete();
    tx_exp.delete();
    tx_got.delete();
    base_wr  = wr_cnt;
    busy_len = 3;
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(3))
        0: begin
          cpu_read(BASE, d);
          if (d != 16'h0000) begin
            if (rx_model.size() == 0) check("rnd_rx_unexpected", d, 16'h0000);
            else check("rnd_rx_data", d, {8'h00, rx_model.pop_front()});
          end
        end
        1: begin
          if ((tx_exp.size() - (wr_cnt - base_wr)) < TX_DEPTH - 1) begin
            b = 8'($urandom);
            tx_exp.push_back(b);
            cpu_write(BASE + 16'd1, {8'h00, b});
          end else tick(1);
        end
        2: begin
          if (rx_q.size() < 3) begin
            b = 8'($urandom_range(255, 1));
            rx_q.push_back(b);
            rx_model.push_back(b);
          end
          tick(1);
        end
        default: begin
          cpu_read(BASE + 16'd2, d);
          check("rnd_status_tx", d & 16'h000A, 16'h0002);
        end
      endcase
    end
    tick(30);
    for (int i = 0; i < 64 && rx_model.size() > 0; i++) begin
      cpu_read(BASE, d);
      if (d != 16'h0000) check("rnd_rx_drain", d, {8'h00, rx_model.pop_front()});
      else tick(1);
    end
    check("rnd_rx_all_seen", 16'(rx_model.size()), 16'd0);
    for (int i = 0; i < 600 && (wr_cnt - base_wr) < tx_exp.size(); i++) tick(1);
    check("rnd_tx_count", 16'(tx_got.size()), 16'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      check("rnd_tx_byte", 16'(tx_got[i]), 16'(tx_exp[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_io_port.md
Name: uart_io_port

Overview:
- J1 I/O-bus responder that sits between the j1 CPU I/O port and the buart byte UART.
- Adds a buffered RX FIFO, a buffered TX FIFO and a pollable status register.
- Paces buart's rd/wr strobes so the CPU never loses received bytes or overruns the transmitter.
- Replaces the direct address-decode glue currently in front of buart.

Parameters:
- BASE_ADDR, 16'h4000: base of the 3-word register window.
- RX_DEPTH, 8: RX FIFO entries; power of two, minimum 2.
- TX_DEPTH, 8: TX FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- io_rd  in  1  CPU read strobe
- io_wr  in  1  CPU write strobe
- io_addr  in  16  CPU I/O address
- io_dout  in  16  CPU write data
- io_din  out  16  read data to CPU
- uart_rd  out  1  pop strobe to buart
- uart_wr  out  1  transmit strobe to buart
- uart_tx_data  out  8  byte to buart
- uart_rx_data  in  8  byte from buart
- uart_valid  in  1  buart holds a received byte
- uart_busy  in  1  buart transmitting

Behaviour:
- Register map:
  - BASE+0, read: RX data. Returns {8'h00, byte} and pops the RX FIFO. If empty, returns 16'h0000 with no pop.
  - BASE+1, write: io_dout[7:0] is pushed to the TX FIFO. If full, the byte is dropped and tx_drop is set.
  - BASE+2, read: status = {12'h0, tx_drop, rx_ovf, tx_ready, rx_avail}.
    - rx_avail: RX FIFO not empty.
    - tx_ready: TX FIFO not full.
  - BASE+2, write: io_dout[2]=1 clears rx_ovf; io_dout[3]=1 clears tx_drop.
- Other addresses are ignored; io_din holds its value.
- Read latency: io_din is registered and valid the cycle after io_rd. It holds until the next decoded read.
- Simultaneous io_rd and io_wr are honoured independently.
- RX FSM (RX_IDLE, RX_HOLD):
  - RX_IDLE: if uart_valid and RX not full, pulse uart_rd for 1 cycle, push uart_rx_data in the same cycle, go to RX_HOLD.
  - RX_HOLD: one dead cycle while buart drops valid, then return to RX_IDLE.
  - If uart_valid and RX full: no ack; buart holds the byte; rx_ovf (sticky) is set on the first such cycle.
- TX FSM (TX_IDLE, TX_START, TX_WAIT):
  - TX_IDLE: if TX not empty and !uart_busy, pulse uart_wr with uart_tx_data = FIFO head, pop, go to TX_START.
  - TX_START: one cycle for busy to rise.
  - TX_WAIT: stay until !uart_busy, then go to TX_IDLE.
  - uart_tx_data is registered and holds the last byte sent.
- FIFOs:
  - Simultaneous push and pop in one cycle is legal. Count is unchanged; data ordering is preserved.
  - Pointers wrap modulo depth. Full is count==DEPTH; empty is count==0.
  - An RX CPU pop and a UART push in the same cycle are both honoured.
- Reset (synchronous, takes effect mid-operation):
  - FIFOs are emptied; both FSMs go to IDLE; sticky flags are cleared.
  - io_din=0, uart_rd=0, uart_wr=0, uart_tx_data=0.
  - A byte in flight inside buart is not cancelled.

Optional Feature:
- Macro UART_IRQ_EN.
- Defined:
  - Adds output irq (1 bit) and control bit ien (reset 0).
  - ien is written via BASE+2 io_dout[8] and read back at status[8].
  - irq = ien & rx_avail, registered, 1-cycle latency. Intended to drive j1 interrupt_request.
- Undefined: no irq port; status[8] reads 0; bit 8 writes are ignored.

Decomposition:
- Shared package uart_io_pkg:
  - Register offsets: RX_OFS=0, TX_OFS=1, STAT_OFS=2.
  - Status bit indices.
  - RX and TX FSM state enums.
- Sub-module sync_fifo (WIDTH, DEPTH), instantiated twice with WIDTH=8.

Test Plan:
- Single RX byte: buart presents 8'h41 with valid → exactly one uart_rd pulse; status reads 16'h0003; RX read returns 16'h0041; status then reads 16'h0002.
- RX overflow: 9 bytes arrive with CPU idle, RX_DEPTH=8 → 8 uart_rd pulses, 9th byte unacked, status bit2=1. CPU drains 0x00..0x07 in order; 9th byte is then accepted. Write 16'h0004 to BASE+2 → bit2=0.
- TX burst: CPU writes 8'h10..8'h17 back-to-back, busy held 20 cycles per byte → 8 uart_wr pulses, each only after busy falls, bytes in order. A 9th write while full sets tx_drop and is not sent.
- Simultaneous ops: RX push and CPU RX pop in the same cycle with count=3 → count stays 3; data order intact.
- Empty read / reset: RX read when empty returns 16'h0000 and keeps count 0. Reset asserted during TX_WAIT → uart_wr stays 0; FIFOs empty; status=16'h0002 after reset.
- UART_IRQ_EN: write 16'h0100 to BASE+2, push one RX byte → irq rises one cycle after rx_avail. Reading the byte drops irq the cycle after the FIFO empties.
